// File: rtl/uart_pkg.sv
// Shared types for the UART TX scheduler.
// UART_TX_PARITY_EN adds the even-parity PAR state to the frame.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_sched_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_sched_state_e;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector; a held lock restricts the grant to the owner.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               lock_i,
  input  logic [ID_W-1:0]    owner_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    gnt_id_c
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_c    = '0;
    gnt_id_c = '0;
    found    = 1'b0;
    cand     = 0;
    if (lock_i) begin
      if (req_i[owner_i]) begin
        gnt_c[owner_i] = 1'b1;
        gnt_id_c       = owner_i;
      end
    end else begin
      // ptr_i + k never exceeds 2*NUM_REQ-2, so a single subtract wraps it
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = 32'(ptr_i) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!found && req_i[cand]) begin
          found       = 1'b1;
          gnt_c[cand] = 1'b1;
          gnt_id_c    = ID_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter with packet locking; 8N1-style framing.
// Define UART_TX_PARITY_EN to append an even parity bit before the stop bit.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  parameter int unsigned  DATA_W  = 8,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bit_tick_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      lock_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  tx_sched_state_e     state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                lock_q, lock_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic [NUM_REQ-1:0]  arb_gnt_c;
  logic [ID_W-1:0]     arb_id_c;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .lock_i   (lock_q),
    .owner_i  (grant_id_q),
    .gnt_c    (arb_gnt_c),
    .gnt_id_c (arb_id_c)
  );

  assign sel_data = req_data_i[32'(arb_id_c)*DATA_W +: DATA_W];
  assign sel_last = req_last_i[arb_id_c];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    lock_d     = lock_q;
    ready_d    = '0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt_c) begin
          ready_d    = arb_gnt_c;
          shift_d    = sel_data;
          grant_id_d = arb_id_c;
          lock_d     = ~sel_last;
`ifdef UART_TX_PARITY_EN
          par_d      = ^sel_data;
`endif
          // pointer moves past the owner only when its packet completes
          if (sel_last) begin
            ptr_d = (arb_id_c == ID_W'(NUM_REQ - 1)) ? '0 : arb_id_c + ID_W'(1);
          end
          state_d = ST_WAIT;
        end
      end
      ST_WAIT:  if (bit_tick_i) state_d = ST_START;
      ST_START: begin
        if (bit_tick_i) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick_i) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PAR:   if (bit_tick_i) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_tick_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // line level follows the state being entered so tx changes on the tick edge
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      ST_START: tx_d = ~UART_IDLE_LEVEL;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PAR:   tx_d = par_d;
`endif
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      lock_q     <= 1'b0;
      ready_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      lock_q     <= lock_d;
      ready_q    <= ready_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_id_q;
  assign lock_o      = lock_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-driven requesters, serial
// frame decoder and a round-robin/lock reference model.
module tb_uart_tx_scheduler;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = $clog2(NR);
  localparam int P   = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [15:0]   gap;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rst_s = 1'b1;
  logic             bit_tick = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             tx, busy, lock;
  logic [IDW-1:0]   grant_id;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bit_tick_i  (bit_tick),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .grant_id_o  (grant_id),
    .lock_o      (lock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_s <= rst;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  ent_t          pq[NR][$];
  int            gap_cnt[NR];
  int            acc_q[$];
  logic          acc_lock_q[$];
  logic [DW-1:0] exp_q[$];
  int            m_ptr = 0, m_owner = 0;
  logic          m_lock = 1'b0;
  int            cyc = 0, tick_cnt = 0, acc_cyc = 0, frames_done = 0;
  int            mstate = 0, mbits = 0;
  logic [DW-1:0] mdata = '0, last_frame = '0;
  logic          last_par = 1'b0, tx_prev = 1'b1;
  logic [NR-1:0] ready_prev = '0, last_ready = '0;

  // spec-level pick: owner only while locked, else first valid at/after pointer
  function automatic int model_pick(input logic [NR-1:0] v);
    int j;
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      j = (m_ptr + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic push(input int r, input logic [DW-1:0] d, input logic l, input int g);
    ent_t e;
    e.data = d;
    e.last = l;
    e.gap  = 16'(g);
    pq[r].push_back(e);
  endtask

  always @(negedge clk) begin : mon
    int idx;
    bit tick_now;
    tick_now = bit_tick;
    cyc++;
    if (rst_s) begin
      m_ptr = 0; m_owner = 0; m_lock = 1'b0;
      exp_q.delete();
      mstate = 0; mbits = 0;
    end else begin
      if (!tick_now) check_eq("tx_stable_between_ticks", 32'(tx), 32'(tx_prev));
      if (ready_prev != '0) check_eq("ready_single_cycle", 32'(req_ready), 32'(0));
      if (req_ready != '0) begin
        idx = 0;
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) idx = i;
        last_ready = req_ready;
        check_eq("ready_onehot", 32'($onehot(req_ready)), 32'(1));
        check_eq("grant_index", 32'(idx), 32'(model_pick(req_valid)));
        check_eq("grant_id_o", 32'(grant_id), 32'(idx));
        check_eq("lock_o_at_accept", 32'(lock), 32'(!req_last[idx]));
        check_eq("busy_at_accept", 32'(busy), 32'(1));
        acc_q.push_back(idx);
        acc_lock_q.push_back(lock);
        exp_q.push_back(req_data[idx*DW +: DW]);
        acc_cyc = cyc;
        m_owner = idx;
        m_lock  = !req_last[idx];
        if (req_last[idx]) m_ptr = (idx + 1) % NR;
        if (pq[idx].size() > 0) void'(pq[idx].pop_front());
        req_valid[idx] = 1'b0;
        gap_cnt[idx]   = 0;
      end
      if (tick_now) begin
        case (mstate)
          0: if (tx == 1'b0) begin
            check_eq("start_latency_in_range",
                     32'((cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= P + 1), 32'(1));
            check_eq("start_has_accept", 32'(exp_q.size() > 0), 32'(1));
            mstate = 1; mbits = 0; mdata = '0;
          end
          1: begin
            mdata[mbits] = tx;
            mbits++;
            if (mbits == DW) mstate = PAR_EN ? 2 : 3;
          end
          2: begin
            last_par = tx;
            check_eq("parity_bit", 32'(tx), 32'(^mdata));
            mstate = 3;
          end
          default: begin
            check_eq("stop_bit", 32'(tx), 32'(1));
            last_frame = mdata;
            if (exp_q.size() > 0) check_eq("frame_data", 32'(mdata), 32'(exp_q.pop_front()));
            frames_done++;
            mstate = 0;
          end
        endcase
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] && pq[i].size() > 0) begin
        if (gap_cnt[i] < int'(pq[i][0].gap)) gap_cnt[i]++;
        else begin
          req_valid[i]          = 1'b1;
          req_data[i*DW +: DW]  = pq[i][0].data;
          req_last[i]           = pq[i][0].last;
        end
      end
    end
    tx_prev    = tx;
    ready_prev = req_ready;
    tick_cnt++;
    bit_tick = ((tick_cnt % P) == 0);
  end

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (frames_done < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (frames_done < n) check_eq("frame_timeout", 32'(frames_done), 32'(n));
    repeat (P + 4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx"},       32'(tx),        32'(1));
    check_eq({tag, "_ready"},    32'(req_ready), 32'(0));
    check_eq({tag, "_busy"},     32'(busy),      32'(0));
    check_eq({tag, "_grant_id"}, 32'(grant_id),  32'(0));
    check_eq({tag, "_lock"},     32'(lock),      32'(0));
  endtask

  initial begin : stim
    int n0, total, len, r, c;
    int rr_exp[5];
    int lk_exp[4];
    int lk_lock[4];
    int st_exp[3];
    for (int i = 0; i < NR; i++) gap_cnt[i] = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // round robin from pointer 0
    acc_q.delete();
    n0 = frames_done;
    push(0, DW'($urandom), 1'b1, 0);
    push(1, DW'($urandom), 1'b1, 0);
    push(2, DW'($urandom), 1'b1, 0);
    push(3, DW'($urandom), 1'b1, 0);
    push(0, DW'($urandom), 1'b1, 0);
    wait_frames(n0 + 5, 3000);
    rr_exp = '{0, 1, 2, 3, 0};
    check_eq("rr_count", 32'(acc_q.size()), 32'(5));
    for (int k = 0; k < 5; k++)
      if (k < acc_q.size()) check_eq("rr_order", 32'(acc_q[k]), 32'(rr_exp[k]));

    // single byte 0xA5 from requester 0
    acc_q.delete();
    n0 = frames_done;
    push(0, 8'hA5, 1'b1, 0);
    wait_frames(n0 + 1, 1000);
    check_eq("single_ready_vec", 32'(last_ready), 32'(4'b0001));
    check_eq("single_frame", 32'(last_frame), 32'(8'hA5));
    check_eq("single_busy_low", 32'(busy), 32'(0));
    check_eq("single_tx_idle", 32'(tx), 32'(1));

    // packet lock: req1 three bytes, req2 waiting
    acc_q.delete();
    acc_lock_q.delete();
    n0 = frames_done;
    push(1, DW'($urandom), 1'b0, 0);
    push(1, DW'($urandom), 1'b0, 0);
    push(1, DW'($urandom), 1'b1, 0);
    push(2, DW'($urandom), 1'b1, 0);
    wait_frames(n0 + 4, 3000);
    lk_exp  = '{1, 1, 1, 2};
    lk_lock = '{1, 1, 0, 0};
    check_eq("lock_count", 32'(acc_q.size()), 32'(4));
    for (int k = 0; k < 4; k++)
      if (k < acc_q.size()) begin
        check_eq("lock_order", 32'(acc_q[k]), 32'(lk_exp[k]));
        check_eq("lock_flag", 32'(acc_lock_q[k]), 32'(lk_lock[k]));
      end

    // owner stalls mid-packet while req3 is valid
    acc_q.delete();
    n0 = frames_done;
    push(1, DW'($urandom), 1'b0, 0);
    push(1, DW'($urandom), 1'b1, 400);
    push(3, DW'($urandom), 1'b1, 5);
    wait_frames(n0 + 1, 1000);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check_eq("stall_tx_high", 32'(tx), 32'(1));
    check_eq("stall_lock_held", 32'(lock), 32'(1));
    check_eq("stall_not_busy", 32'(busy), 32'(0));
    check_eq("stall_owner", 32'(grant_id), 32'(1));
    @(posedge clk); #1;
    wait_frames(n0 + 3, 3000);
    st_exp = '{1, 1, 3};
    check_eq("stall_count", 32'(acc_q.size()), 32'(3));
    for (int k = 0; k < 3; k++)
      if (k < acc_q.size()) check_eq("stall_order", 32'(acc_q[k]), 32'(st_exp[k]));

    // reset while data bit 4 is on the line
    push(2, 8'h3C, 1'b1, 0);
    c = 0;
    while (!(mstate == 1 && mbits == 5) && c < 1000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 1000) check_eq("reset_wait_timeout", 32'(mbits), 32'(5));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk); #1 rst = 1'b0;
    acc_q.delete();
    n0 = frames_done;
    push(3, DW'($urandom), 1'b1, 0);
    push(0, DW'($urandom), 1'b1, 0);
    wait_frames(n0 + 2, 2000);
    check_eq("post_reset_count", 32'(acc_q.size()), 32'(2));
    if (acc_q.size() > 0) check_eq("post_reset_first", 32'(acc_q[0]), 32'(0));

`ifdef UART_TX_PARITY_EN
    n0 = frames_done;
    push(1, 8'h07, 1'b1, 0);
    wait_frames(n0 + 1, 1000);
    check_eq("parity_frame", 32'(last_frame), 32'(8'h07));
    check_eq("parity_07", 32'(last_par), 32'(1));
`endif

    // randomized packets across all requesters
    n0 = frames_done;
    total = 0;
    for (int p = 0; p < 20; p++) begin
      r   = int'($urandom_range(0, NR - 1));
      len = int'($urandom_range(1, 3));
      for (int b = 0; b < len; b++) begin
        push(r, DW'($urandom), (b == len - 1), int'($urandom_range(0, 30)));
        total++;
      end
    end
    wait_frames(n0 + total, 40000);
    c = 0;
    for (int i = 0; i < NR; i++) c += pq[i].size();
    check_eq("queues_drained", 32'(c), 32'(0));
    check_eq("no_pending_frames", 32'(exp_q.size()), 32'(0));
    check_eq("final_busy_low", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
